keypad_entry: RTL and testbench

Mouse-driven input front end for the VGA calculator. It takes the pointer position and left-button state, hit-tests the press against the on-screen keypad grid, and turns the hit into a key code. A digit-entry state machine builds two 33-bit sign-magnitude operands and an operator, then hands them to the ALU. It feeds the ALU result, or the operand being typed, back to the display path as a 33-bit value.

---
 rtl/keypad_entry_if.sv | 20 ++
 rtl/keypad_entry.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_entry.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// ALU handshake bundle between the keypad front end and the arithmetic unit.
// Operands and results use sign-magnitude encoding: bit 32 is the sign.
interface keypad_entry_if;
    logic [32:0] num_a;
    logic [32:0] num_b;
    logic [1:0]  op;
    logic        calc_start;
    logic [32:0] alu_result;
    logic        alu_done;

    modport master (
        output num_a, num_b, op, calc_start,
        input  alu_result, alu_done
    );

    modport slave (
        input  num_a, num_b, op, calc_start,
        output alu_result, alu_done
    );
endinterface

// File: rtl/keypad_entry.sv
// Mouse-driven keypad front end for the calculator: synchronizes clicks, hit-tests
// the on-screen grid, and runs operand/operator entry toward the ALU.
module keypad_entry #(
    parameter logic [31:0] MAX_MAG = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            mouse_x,
    input  logic [8:0]            mouse_y,
    input  logic                  btn_left,
    keypad_entry_if.master        alu,
    output logic [32:0]           display_value,
    output logic                  key_valid,
    output logic [4:0]            key_code,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        WAIT_ALU = 2'd2,
        SHOW     = 2'd3
    } state_t;

    logic       sync1, sync2, sync2_d, armed;
    logic [1:0] flush;
    logic       press;
    logic       press_hit;
    logic [4:0] press_code;

    // armed only after a low level has come through the synchronizer post-reset,
    // so a button held across reset release must be released before it counts.
    assign press = sync2 & ~sync2_d & armed;

    logic [1:0] row;
    logic [2:0] col;
    logic       row_hit, col_hit, cell_hit;
    logic [4:0] cell_code;

    always_comb begin
        row     = '0;
        row_hit = 1'b0;
        col     = '0;
        col_hit = 1'b0;
        for (int unsigned r = 0; r < 3; r++) begin
            if (mouse_y >= 9'(204 + 44 * r) && mouse_y < 9'(228 + 44 * r)) begin
                row     = 2'(r);
                row_hit = 1'b1;
            end
        end
        for (int unsigned c = 0; c < 6; c++) begin
            if (mouse_x >= 10'(220 + 44 * c) &&
                mouse_x < 10'((c == 5) ? 462 : (244 + 44 * c))) begin
                col     = 3'(c);
                col_hit = 1'b1;
            end
        end
        cell_hit  = row_hit & col_hit & ~(row == 2'd2 && col == 3'd5);
        cell_code = 5'(row) * 5'd6 + 5'(col);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync2_d    <= 1'b0;
            flush      <= '0;
            armed      <= 1'b0;
            press_hit  <= 1'b0;
            press_code <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
        end else begin
            sync1   <= btn_left;
            sync2   <= sync1;
            sync2_d <= sync2;
            flush   <= {flush[0], 1'b1};
            if (flush[1] && !sync2)
                armed <= 1'b1;
            press_hit <= press & cell_hit;
            if (press && cell_hit)
                press_code <= cell_code;
            key_valid <= press_hit;
            if (press_hit)
                key_code <= press_code;
        end
    end

    state_t      st, nxt_st;
    logic [32:0] num_a_q, num_b_q, res_q;
    logic [32:0] nxt_a, nxt_b, nxt_res, nxt_disp;
    logic [1:0]  op_q, nxt_op;
    logic        b_ent, nxt_b_ent;
    logic        start_q, nxt_start;

    logic        is_digit, is_op, is_eq, is_clr, is_pm;
    logic [1:0]  key_op;
    logic [32:0] cur, dig_val, pm_val;
    logic [35:0] prod;
    logic        dig_ok, pm_ok;

    always_comb begin
        is_digit = key_code < 5'd10;
        is_op    = key_code >= 5'd10 && key_code <= 5'd13;
        is_eq    = key_code == 5'd14;
        is_clr   = key_code == 5'd15;
        is_pm    = key_code == 5'd16;
        key_op   = 2'(key_code - 5'd10);
        cur      = (st == ENTER_B) ? num_b_q : num_a_q;
        prod     = 36'(cur[31:0]) * 36'd10 + 36'(key_code);
        dig_ok   = prod <= 36'(MAX_MAG);
        dig_val  = {cur[32], prod[31:0]};
        pm_ok    = cur[31:0] != '0;
        pm_val   = {~cur[32], cur[31:0]};
    end

    always_comb begin
        nxt_st    = st;
        nxt_a     = num_a_q;
        nxt_b     = num_b_q;
        nxt_res   = res_q;
        nxt_op    = op_q;
        nxt_b_ent = b_ent;
        nxt_start = 1'b0;
        if (key_valid && is_clr) begin
            nxt_st    = ENTER_A;
            nxt_a     = '0;
            nxt_b     = '0;
            nxt_res   = '0;
            nxt_op    = '0;
            nxt_b_ent = 1'b0;
        end else begin
            case (st)
                ENTER_A: if (key_valid) begin
                    if (is_digit && dig_ok)
                        nxt_a = dig_val;
                    else if (is_pm && pm_ok)
                        nxt_a = pm_val;
                    else if (is_op) begin
                        nxt_op    = key_op;
                        nxt_b     = '0;
                        nxt_b_ent = 1'b0;
                        nxt_st    = ENTER_B;
                    end
                end
                ENTER_B: if (key_valid) begin
                    if (is_digit && dig_ok) begin
                        nxt_b     = dig_val;
                        nxt_b_ent = 1'b1;
                    end else if (is_pm && pm_ok) begin
                        nxt_b     = pm_val;
                        nxt_b_ent = 1'b1;
                    end else if (is_op && !b_ent)
                        nxt_op = key_op;
                    else if (is_eq) begin
                        nxt_start = 1'b1;
                        nxt_st    = WAIT_ALU;
                    end
                end
                WAIT_ALU: if (alu.alu_done) begin
                    nxt_res = alu.alu_result;
                    nxt_st  = SHOW;
                end
                SHOW: if (key_valid) begin
                    if (is_digit) begin
                        nxt_a  = 33'(key_code);
                        nxt_b  = '0;
                        nxt_st = ENTER_A;
                    end else if (is_op) begin
                        nxt_a     = res_q;
                        nxt_op    = key_op;
                        nxt_b     = '0;
                        nxt_b_ent = 1'b0;
                        nxt_st    = ENTER_B;
                    end
                end
                default: nxt_st = ENTER_A;
            endcase
        end
        case (nxt_st)
            ENTER_A: nxt_disp = nxt_a;
            SHOW:    nxt_disp = nxt_res;
            default: nxt_disp = nxt_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st            <= ENTER_A;
            num_a_q       <= '0;
            num_b_q       <= '0;
            res_q         <= '0;
            op_q          <= '0;
            b_ent         <= 1'b0;
            start_q       <= 1'b0;
            display_value <= '0;
        end else begin
            st            <= nxt_st;
            num_a_q       <= nxt_a;
            num_b_q       <= nxt_b;
            res_q         <= nxt_res;
            op_q          <= nxt_op;
            b_ent         <= nxt_b_ent;
            start_q       <= nxt_start;
            display_value <= nxt_disp;
        end
    end

    assign alu.num_a      = num_a_q;
    assign alu.num_b      = num_b_q;
    assign alu.op         = op_q;
    assign alu.calc_start = start_q;
    assign state          = st;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed scenarios plus random clicks,
// compared against a signed-integer calculator model.
module tb_keypad_entry;

    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  mouse_x;
    logic [8:0]  mouse_y;
    logic        btn_left;
    logic [32:0] display_value;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [1:0]  state;

    keypad_entry_if alu();

    keypad_entry #(.MAX_MAG(32'hFFFF_FFFF)) dut (
        .clk          (clk),
        .reset        (reset),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .btn_left     (btn_left),
        .alu          (alu),
        .display_value(display_value),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    int          m_state;
    longint      m_a, m_b;
    logic [32:0] m_res;
    int          m_op;
    bit          m_bent;
    bit          m_start;

    function automatic logic [32:0] enc(longint v);
        longint mag;
        mag = (v < 0) ? -v : v;
        return {v < 0, mag[31:0]};
    endfunction

    function automatic longint dec(logic [32:0] v);
        longint mag;
        mag = {32'b0, v[31:0]};
        return v[32] ? -mag : mag;
    endfunction

    function automatic int hit(int x, int y);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 6; c++)
                if (!(r == 2 && c == 5) &&
                    x >= 220 + 44 * c && x < 220 + 44 * c + ((c == 5) ? 22 : 24) &&
                    y >= 204 + 44 * r && y < 228 + 44 * r)
                    return r * 6 + c;
        return -1;
    endfunction

    function automatic int kx(int k);
        return 230 + 44 * (k % 6);
    endfunction

    function automatic int ky(int k);
        return 214 + 44 * (k / 6);
    endfunction

    task automatic model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_res = '0; m_op = 0; m_bent = 0; m_start = 0;
    endtask

    task automatic apply_key(int k);
        longint cur, mag, n, nv;
        bit     upd;
        m_start = 0;
        upd = 0;
        nv  = 0;
        cur = (m_state == 1) ? m_b : m_a;
        mag = (cur < 0) ? -cur : cur;
        if (k == 15) begin
            model_reset();
        end else if (m_state == 0 || m_state == 1) begin
            if (k < 10) begin
                n = mag * 10 + k;
                if (n <= MAXV) begin
                    upd = 1;
                    nv  = (cur < 0) ? -n : n;
                end
            end else if (k == 16) begin
                if (mag != 0) begin
                    upd = 1;
                    nv  = -cur;
                end
            end else if (k <= 13) begin
                if (m_state == 0) begin
                    m_op = k - 10; m_b = 0; m_bent = 0; m_state = 1;
                end else if (!m_bent) begin
                    m_op = k - 10;
                end
            end else if (k == 14 && m_state == 1) begin
                m_start = 1;
                m_state = 2;
            end
            if (upd) begin
                if (m_state == 1) begin
                    m_b = nv; m_bent = 1;
                end else begin
                    m_a = nv;
                end
            end
        end else if (m_state == 3) begin
            if (k < 10) begin
                m_a = k; m_b = 0; m_state = 0;
            end else if (k <= 13) begin
                m_a = dec(m_res); m_op = k - 10; m_b = 0; m_bent = 0; m_state = 1;
            end
        end
    endtask

    task automatic check(string tag, logic [35:0] obs, logic [35:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        logic [32:0] exp_disp;
        case (m_state)
            0:       exp_disp = enc(m_a);
            3:       exp_disp = m_res;
            default: exp_disp = enc(m_b);
        endcase
        check({tag, ".state"},   36'(state),          36'(m_state));
        check({tag, ".num_a"},   36'(alu.num_a),      36'(enc(m_a)));
        check({tag, ".num_b"},   36'(alu.num_b),      36'(enc(m_b)));
        check({tag, ".op"},      36'(alu.op),         36'(m_op));
        check({tag, ".display"}, 36'(display_value),  36'(exp_disp));
        check({tag, ".start"},   36'(alu.calc_start), 36'(m_start));
    endtask

    task automatic click(int x, int y, int hold);
        int k, extra, starts;
        k = hit(x, y);
        extra = 0;
        starts = 0;
        @(posedge clk); #1;
        mouse_x = 10'(x); mouse_y = 9'(y); btn_left = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("kv_early", 36'(key_valid), 36'(0));
        @(posedge clk); #1;
        check("key_valid", 36'(key_valid), 36'(k >= 0));
        if (k >= 0) begin
            check("key_code", 36'(key_code), 36'(k));
            apply_key(k);
        end else begin
            m_start = 0;
        end
        @(posedge clk); #1;
        check("kv_pulse", 36'(key_valid), 36'(0));
        check_outputs("click");
        m_start = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            extra  += int'(key_valid);
            starts += int'(alu.calc_start);
        end
        btn_left = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            extra  += int'(key_valid);
            starts += int'(alu.calc_start);
        end
        check("no_repeat", 36'(extra), 36'(0));
        check("start_once", 36'(starts), 36'(0));
    endtask

    task automatic key(int k);
        click(kx(k), ky(k), 1);
    endtask

    task automatic alu_step(logic [32:0] v);
        @(posedge clk); #1;
        alu.alu_result = v;
        alu.alu_done   = 1'b1;
        @(posedge clk); #1;
        alu.alu_done = 1'b0;
        if (m_state == 2) begin
            m_res   = v;
            m_state = 3;
        end
        m_start = 0;
        check_outputs("alu");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int digs[10];
        int k, x, y;
        logic [32:0] rv;

        reset = 1'b1; btn_left = 1'b0; mouse_x = '0; mouse_y = '0;
        alu.alu_result = '0; alu.alu_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check_outputs("reset");
        check("reset.key_valid", 36'(key_valid), 36'(0));
        check("reset.key_code",  36'(key_code),  36'(0));

        // digit entry
        key(1); key(2); key(3);
        check("a_is_123", 36'(alu.num_a), 36'(33'd123));
        check("disp_123", 36'(display_value), 36'(33'd123));

        // full calculation 12 + 30 =
        key(15); key(1); key(2); key(10); key(3); key(0); key(14);
        check("calc.a", 36'(alu.num_a), 36'(33'd12));
        check("calc.b", 36'(alu.num_b), 36'(33'd30));
        check("calc.op", 36'(alu.op), 36'(2'b00));
        alu_step(33'd42);
        check("show.state", 36'(state), 36'(2'd3));
        check("show.disp", 36'(display_value), 36'(33'd42));

        // chaining from the result
        key(12); key(2);
        check("chain.a", 36'(alu.num_a), 36'(33'd42));
        check("chain.op", 36'(alu.op), 36'(2'b10));
        check("chain.b", 36'(alu.num_b), 36'(33'd2));

        // misses and long hold
        click(230, 240, 1);
        click(465, 210, 1);
        click(kx(7), ky(7), 1000);

        // overflow guard and sign toggle
        key(15);
        digs = '{4, 2, 9, 4, 9, 6, 7, 2, 9, 5};
        foreach (digs[i]) key(digs[i]);
        key(0);
        check("ovf.a", 36'(alu.num_a), 36'(33'h0_FFFF_FFFF));
        key(16);
        check("pm.sign", 36'(alu.num_a[32]), 36'(1'b1));
        key(15); key(16);
        check("pm.zero", 36'(alu.num_a), 36'(33'd0));

        // abort a pending calculation
        key(5); key(10); key(6); key(14); key(15);
        alu_step(33'd99);
        check("abort.state", 36'(state), 36'(2'd0));
        check("abort.disp", 36'(display_value), 36'(33'd0));

        // reset in the middle of a press
        key(4);
        @(posedge clk); #1;
        mouse_x = 10'(kx(3)); mouse_y = 9'(ky(3)); btn_left = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check_outputs("midreset");
        begin
            int kv_seen;
            kv_seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                kv_seen += int'(key_valid);
            end
            btn_left = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("midreset.no_key", 36'(kv_seen), 36'(0));
            check("midreset.code", 36'(key_code), 36'(0));
            check_outputs("midreset.after");
        end
        key(8);

        // random clicks against the model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
            end else begin
                k = int'($urandom_range(0, 16));
                if (k == 15 && $urandom_range(0, 3) != 0)
                    k = int'($urandom_range(0, 9));
                x = 220 + 44 * (k % 6) + int'($urandom_range(0, (k % 6 == 5) ? 21 : 23));
                y = 204 + 44 * (k / 6) + int'($urandom_range(0, 23));
            end
            click(x, y, int'($urandom_range(0, 3)));
            if (m_state == 2 || $urandom_range(0, 5) == 0) begin
                rv = {1'($urandom_range(0, 1)), 32'($urandom_range(1, 32'hFFFF_FFFF))};
                alu_step(rv);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
